// File: rtl/picorv_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : picorv_bus_arbiter
//  Purpose  : Round-robin arbiter that lets two PicoRV32 native-interface
//             masters (m0 = core, m1 = loader/DMA) share one slave port. The
//             grant is held until the slave completes, and s_mem_valid always
//             drops for at least one cycle between grants.
//  Options  : PICORV_ARB_TIMEOUT_EN - adds a slave watchdog (TIMEOUT_CYCLES)
//             that completes a stuck access with ERR_RDATA and counts errors.
//  Revision : 1.0 - initial release
// ============================================================================
module picorv_bus_arbiter #(
`ifdef PICORV_ARB_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 256,
`endif
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_mem_valid,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,

    input  logic        m1_mem_valid,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,

    output logic        s_mem_valid,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,

    output logic [1:0]  grant,
    output logic        bus_err,
    output logic [7:0]  err_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nxt;
    logic        r_last;        // 0: m0 was served last, 1: m1 was served last
    logic        w_last_nxt;

    logic        w_busy;
    logic        w_sel;         // 1 when m1 owns the slave port
    logic        w_req_valid;   // valid of the current owner
    logic        w_done;        // slave completes this cycle
    logic        w_abort;       // owner withdrew before completion
    logic        w_timeout;     // watchdog completes this cycle

    assign w_busy      = (r_state == BUSY);
    assign w_sel       = r_grant[1];
    assign w_req_valid = w_sel ? m1_mem_valid : m0_mem_valid;
    assign w_done      = w_busy & s_mem_ready;
    assign w_abort     = w_busy & ~s_mem_ready & ~w_req_valid;

`ifdef PICORV_ARB_TIMEOUT_EN
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_to_cnt;
    logic [7:0]  r_err_count;

    // The slave wins a tie with the watchdog, so a ready in the limit cycle
    // still returns real data.
    assign w_timeout = w_busy & w_req_valid & ~s_mem_ready & (r_to_cnt == c_TO_LAST);

    // Wait counter: cleared while idle (i.e. on entry to BUSY), counts stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt <= 16'd0;
        end else if (!w_busy) begin
            r_to_cnt <= 16'd0;
        end else if (!s_mem_ready) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    // Saturating count of watchdog expiries.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_count <= 8'd0;
        end else if (w_timeout && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus_err   = w_timeout;
    assign err_count = r_err_count;
`else
    // No watchdog: BUSY waits for the slave indefinitely.
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
    assign err_count = 8'd0;
`endif

    // State, grant and round-robin history registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for completion or abort in BUSY.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (m0_mem_valid || m1_mem_valid) begin
                    w_state_nxt = BUSY;
                    if (m0_mem_valid && m1_mem_valid) begin
                        w_grant_nxt = r_last ? 2'b01 : 2'b10;
                    end else if (m0_mem_valid) begin
                        w_grant_nxt = 2'b01;
                    end else begin
                        w_grant_nxt = 2'b10;
                    end
                end
            end
            BUSY: begin
                if (w_done || w_timeout) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 2'b00;
                    w_last_nxt  = w_sel;
                end else if (w_abort) begin
                    // History is left alone so the aborting master keeps its turn.
                    w_state_nxt = IDLE;
                    w_grant_nxt = 2'b00;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    // Forward the owner's request to the slave; all zeros while idle.
    always_comb begin
        s_mem_valid = 1'b0;
        s_mem_addr  = 32'd0;
        s_mem_wdata = 32'd0;
        s_mem_wstrb = 4'd0;
        if (w_busy) begin
            s_mem_valid = w_req_valid & ~w_timeout;
            if (w_sel) begin
                s_mem_addr  = m1_mem_addr;
                s_mem_wdata = m1_mem_wdata;
                s_mem_wstrb = m1_mem_wstrb;
            end else begin
                s_mem_addr  = m0_mem_addr;
                s_mem_wdata = m0_mem_wdata;
                s_mem_wstrb = m0_mem_wstrb;
            end
        end
    end

    // Completion is routed only to the owner; rdata of a non-owner is don't-care.
    assign m0_mem_ready = r_grant[0] & (s_mem_ready | w_timeout);
    assign m1_mem_ready = r_grant[1] & (s_mem_ready | w_timeout);
    assign m0_mem_rdata = (r_grant[0] & w_timeout) ? ERR_RDATA : s_mem_rdata;
    assign m1_mem_rdata = (r_grant[1] & w_timeout) ? ERR_RDATA : s_mem_rdata;

    assign grant = r_grant;

endmodule
`default_nettype wire
